// File: rtl/vc32_membus_if.sv
// Requester, invalidate and external-pin signals of the vc32 memory bus controller.
interface vc32_membus_if;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  logic          r0_req;
  logic [AW-1:0] r0_addr;
  logic          r0_we;
  logic [1:0]    r0_wmask;
  logic [DW-1:0] r0_wdata;
  logic          r0_ack;
  logic [DW-1:0] r0_rdata;

  logic          r1_req;
  logic [AW-1:0] r1_addr;
  logic          r1_we;
  logic [1:0]    r1_wmask;
  logic [DW-1:0] r1_wdata;
  logic          r1_ack;
  logic [DW-1:0] r1_rdata;

  logic          inval;
  logic [BW-1:0] bus_out;
  logic [BW-1:0] bus_in;
  logic          bus_ind;
  logic          bus_write;
  logic          bus_latch_hi;
  logic          bus_latch_lo;
  logic          busy;

  // Controller side
  modport slave (
    input  r0_req, r0_addr, r0_we, r0_wmask, r0_wdata,
    input  r1_req, r1_addr, r1_we, r1_wmask, r1_wdata,
    input  inval, bus_in,
    output r0_ack, r0_rdata, r1_ack, r1_rdata,
    output bus_out, bus_ind, bus_write, bus_latch_hi, bus_latch_lo, busy
  );

  // Requesters and pin side
  modport master (
    output r0_req, r0_addr, r0_we, r0_wmask, r0_wdata,
    output r1_req, r1_addr, r1_we, r1_wmask, r1_wdata,
    output inval, bus_in,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata,
    input  bus_out, bus_ind, bus_write, bus_latch_hi, bus_latch_lo, busy
  );
endinterface

// File: rtl/vc32_membus_ctrl.sv
// vc32 multiplexed 8-bit memory bus sequencer with two-port arbitration and
// a cache of the last latched upper address bytes.
module vc32_membus_ctrl #(
  parameter bit CACHE_EN   = 1'b1,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  vc32_membus_if.slave mb
);
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  typedef enum logic [2:0] {IDLE, AHI, AMID, ALO, D0, D1, ACK} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [1:0]    wmask;
    logic [DW-1:0] wdata;
  } req_t;

  state_e        state_q, state_d;
  req_t          req_q, req_d, req0, req1, cand;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic          sel, need_hi, need_mid;

  logic          cache_valid_q;
  logic [1:0]    cached_hi_q;
  logic [7:0]    cached_mid_q;

  logic [BW-1:0] rbuf_lo_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic [BW-1:0] bus_out_q, bus_out_d;
  logic          ind_q, ind_d;
  logic          write_q, write_d;
  logic          lhi_q, lhi_d;
  logic          llo_q, llo_d;
  logic          busy_q, busy_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;

  assign req0 = '{addr: mb.r0_addr, we: mb.r0_we, wmask: mb.r0_wmask, wdata: mb.r0_wdata};
  assign req1 = '{addr: mb.r1_addr, we: mb.r1_we, wmask: mb.r1_wmask, wdata: mb.r1_wdata};

  // Arbitration: lone requester wins; on contention fixed or round-robin.
  always_comb begin
    sel = mb.r1_req;
    if (mb.r0_req && mb.r1_req) begin
      sel = PRIO_FIXED ? 1'b0 : ~last_grant_q;
    end
  end

  assign cand     = sel ? req1 : req0;
  assign need_hi  = !cache_valid_q || !CACHE_EN || (cand.addr[16:15] != cached_hi_q);
  assign need_mid = need_hi || (cand.addr[14:7] != cached_mid_q);

  // Next state, captured request and registered-output values for the entered state.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    bus_out_d    = '0;
    ind_d        = 1'b0;
    write_d      = 1'b0;
    lhi_d        = 1'b0;
    llo_d        = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mb.r0_req || mb.r1_req) begin
          grant_d      = sel;
          last_grant_d = sel;
          req_d        = cand;
          state_d      = need_hi ? AHI : (need_mid ? AMID : ALO);
        end
      end
      AHI:  state_d = AMID;
      AMID: state_d = ALO;
      ALO: begin
        if (!req_q.we)           state_d = D0;
        else if (req_q.wmask[0]) state_d = D0;
        else if (req_q.wmask[1]) state_d = D1;
        else                     state_d = ACK;
      end
      D0:      state_d = (req_q.we && !req_q.wmask[1]) ? ACK : D1;
      D1:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      AHI: begin
        bus_out_d = {6'b0, req_d.addr[16:15]};
        lhi_d     = 1'b1;
      end
      AMID: begin
        bus_out_d = req_d.addr[14:7];
        lhi_d     = 1'b1;
        llo_d     = 1'b1;
      end
      ALO: begin
        bus_out_d = {req_d.addr[6:0], 1'b0};
        llo_d     = 1'b1;
      end
      D0: begin
        if (req_d.we) begin
          bus_out_d = req_d.wdata[7:0];
          write_d   = 1'b1;
        end
      end
      D1: begin
        ind_d = 1'b1;
        if (req_d.we) begin
          bus_out_d = req_d.wdata[15:8];
          write_d   = 1'b1;
        end
      end
      ACK: begin
        ack0_d = !grant_d;
        ack1_d = grant_d;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, captured request and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      bus_out_q    <= '0;
      ind_q        <= 1'b0;
      write_q      <= 1'b0;
      lhi_q        <= 1'b0;
      llo_q        <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      bus_out_q    <= bus_out_d;
      ind_q        <= ind_d;
      write_q      <= write_d;
      lhi_q        <= lhi_d;
      llo_q        <= llo_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  // Upper-address cache: filled at ALO completion, invalidate has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      cached_hi_q   <= '0;
      cached_mid_q  <= '0;
    end else begin
      if (state_q == ALO) begin
        cache_valid_q <= 1'b1;
        cached_hi_q   <= req_q.addr[16:15];
        cached_mid_q  <= req_q.addr[14:7];
      end
      if (mb.inval) begin
        cache_valid_q <= 1'b0;
      end
    end
  end

  // Read data: low byte buffered after D0 so port rdata only changes on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      rbuf_lo_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if ((state_q == D0) && !req_q.we) begin
        rbuf_lo_q <= mb.bus_in;
      end
      if ((state_q == D1) && !req_q.we) begin
        if (grant_q) rdata1_q <= {mb.bus_in, rbuf_lo_q};
        else         rdata0_q <= {mb.bus_in, rbuf_lo_q};
      end
    end
  end

  assign mb.bus_out      = bus_out_q;
  assign mb.bus_ind      = ind_q;
  assign mb.bus_write    = write_q;
  assign mb.bus_latch_hi = lhi_q;
  assign mb.bus_latch_lo = llo_q;
  assign mb.busy         = busy_q;
  assign mb.r0_ack       = ack0_q;
  assign mb.r1_ack       = ack1_q;
  assign mb.r0_rdata     = rdata0_q;
  assign mb.r1_rdata     = rdata1_q;
endmodule

// File: tb/tb_vc32_membus_ctrl.sv
// Directed bench: default build (A), CACHE_EN=0 (B), PRIO_FIXED=1 (C).
module tb_vc32_membus_ctrl;
  logic clk;
  logic reset;
  int   dsel;
  int   checks;
  int   errors;
  int   overlap_cnt;

  logic        r0_req, r1_req, r0_we, r1_we, inval;
  logic [16:0] r0_addr, r1_addr;
  logic [1:0]  r0_wmask, r1_wmask;
  logic [15:0] r0_wdata, r1_wdata;
  logic [7:0]  mem_lo, mem_hi;

  logic [7:0]  o_out;
  logic        o_ind, o_wr, o_hi, o_lo, o_busy, o_ack0, o_ack1;
  logic [15:0] o_rd0, o_rd1;

  logic [7:0]  t_out [0:15];
  logic        t_hi  [0:15];
  logic        t_lo  [0:15];
  logic        t_wr  [0:15];
  logic        t_ind [0:15];
  logic [15:0] t_rd;

  vc32_membus_if ifa ();
  vc32_membus_if ifb ();
  vc32_membus_if ifc ();

  vc32_membus_ctrl dut_a (.clk(clk), .reset(reset), .mb(ifa.slave));
  vc32_membus_ctrl #(.CACHE_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .mb(ifb.slave));
  vc32_membus_ctrl #(.PRIO_FIXED(1'b1)) dut_c (.clk(clk), .reset(reset), .mb(ifc.slave));

  always #5 clk = ~clk;

  assign ifa.r0_req = r0_req && (dsel == 0);
  assign ifa.r1_req = r1_req && (dsel == 0);
  assign ifa.inval  = inval && (dsel == 0);
  assign ifb.r0_req = r0_req && (dsel == 1);
  assign ifb.r1_req = r1_req && (dsel == 1);
  assign ifb.inval  = inval && (dsel == 1);
  assign ifc.r0_req = r0_req && (dsel == 2);
  assign ifc.r1_req = r1_req && (dsel == 2);
  assign ifc.inval  = inval && (dsel == 2);

  assign ifa.r0_addr = r0_addr;  assign ifb.r0_addr = r0_addr;  assign ifc.r0_addr = r0_addr;
  assign ifa.r0_we   = r0_we;    assign ifb.r0_we   = r0_we;    assign ifc.r0_we   = r0_we;
  assign ifa.r0_wmask = r0_wmask; assign ifb.r0_wmask = r0_wmask; assign ifc.r0_wmask = r0_wmask;
  assign ifa.r0_wdata = r0_wdata; assign ifb.r0_wdata = r0_wdata; assign ifc.r0_wdata = r0_wdata;
  assign ifa.r1_addr = r1_addr;  assign ifb.r1_addr = r1_addr;  assign ifc.r1_addr = r1_addr;
  assign ifa.r1_we   = r1_we;    assign ifb.r1_we   = r1_we;    assign ifc.r1_we   = r1_we;
  assign ifa.r1_wmask = r1_wmask; assign ifb.r1_wmask = r1_wmask; assign ifc.r1_wmask = r1_wmask;
  assign ifa.r1_wdata = r1_wdata; assign ifb.r1_wdata = r1_wdata; assign ifc.r1_wdata = r1_wdata;

  // Memory returns a fixed byte pair chosen by the test, indexed by bus_ind.
  assign ifa.bus_in = ifa.bus_ind ? mem_hi : mem_lo;
  assign ifb.bus_in = ifb.bus_ind ? mem_hi : mem_lo;
  assign ifc.bus_in = ifc.bus_ind ? mem_hi : mem_lo;

  // Observe the selected controller.
  always_comb begin
    case (dsel)
      0: begin
        o_out = ifa.bus_out; o_ind = ifa.bus_ind; o_wr = ifa.bus_write;
        o_hi = ifa.bus_latch_hi; o_lo = ifa.bus_latch_lo; o_busy = ifa.busy;
        o_ack0 = ifa.r0_ack; o_ack1 = ifa.r1_ack; o_rd0 = ifa.r0_rdata; o_rd1 = ifa.r1_rdata;
      end
      1: begin
        o_out = ifb.bus_out; o_ind = ifb.bus_ind; o_wr = ifb.bus_write;
        o_hi = ifb.bus_latch_hi; o_lo = ifb.bus_latch_lo; o_busy = ifb.busy;
        o_ack0 = ifb.r0_ack; o_ack1 = ifb.r1_ack; o_rd0 = ifb.r0_rdata; o_rd1 = ifb.r1_rdata;
      end
      default: begin
        o_out = ifc.bus_out; o_ind = ifc.bus_ind; o_wr = ifc.bus_write;
        o_hi = ifc.bus_latch_hi; o_lo = ifc.bus_latch_lo; o_busy = ifc.busy;
        o_ack0 = ifc.r0_ack; o_ack1 = ifc.r1_ack; o_rd0 = ifc.r0_rdata; o_rd1 = ifc.r1_rdata;
      end
    endcase
  end

  // Count cycles where any controller drives a latch strobe together with a write strobe.
  always @(negedge clk) begin
    if ((ifa.bus_write && (ifa.bus_latch_hi || ifa.bus_latch_lo)) ||
        (ifb.bus_write && (ifb.bus_latch_hi || ifb.bus_latch_lo)) ||
        (ifc.bus_write && (ifc.bus_latch_hi || ifc.bus_latch_lo)))
      overlap_cnt++;
  end

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One access on port p of the selected controller; records per-cycle bus activity.
  task automatic do_access(input int p, input logic [16:0] a, input logic we,
                           input logic [1:0] wm, input logic [15:0] wd,
                           input int inval_k, output int lat);
    for (int i = 0; i < 16; i++) begin
      t_out[i] = 8'h0; t_hi[i] = 1'b0; t_lo[i] = 1'b0; t_wr[i] = 1'b0; t_ind[i] = 1'b0;
    end
    t_rd = 16'h0;
    if (p == 0) begin
      r0_addr = a; r0_we = we; r0_wmask = wm; r0_wdata = wd; r0_req = 1'b1;
    end else begin
      r1_addr = a; r1_we = we; r1_wmask = wm; r1_wdata = wd; r1_req = 1'b1;
    end
    lat = 0;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      t_out[k] = o_out; t_hi[k] = o_hi; t_lo[k] = o_lo; t_wr[k] = o_wr; t_ind[k] = o_ind;
      inval = (k == inval_k);
      if ((p == 0 && o_ack0) || (p == 1 && o_ack1)) begin
        lat  = k;
        t_rd = (p == 0) ? o_rd0 : o_rd1;
        break;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0; inval = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [46:0] v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      dsel = d; #1;
      v = {o_out, o_ind, o_wr, o_hi, o_lo, o_busy, o_ack0, o_ack1, o_rd0, o_rd1};
      checks++;
      if (v !== 47'h0) begin
        errors++; $display("FAIL reset_outputs dut%0d got=%h exp=0", d, v);
      end
    end
    dsel = 0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_arbitration(input int d, input logic [3:0] exp_seq);
    int got [0:3];
    int n;
    dsel = d;
    apply_reset();
    r0_addr = 17'h00010; r0_we = 1'b0; r0_wmask = 2'b00; r0_wdata = 16'h0;
    r1_addr = 17'h00020; r1_we = 1'b0; r1_wmask = 2'b00; r1_wdata = 16'h0;
    r0_req = 1'b1; r1_req = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) got[i] = -1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(posedge clk); #1;
      if (o_ack0)      begin got[n] = 0; n++; end
      else if (o_ack1) begin got[n] = 1; n++; end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL arb_count dut%0d got=%0d exp=4", d, n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== int'(exp_seq[i])) begin
        errors++; $display("FAIL arb_grant%0d dut%0d got=%0d exp=%0d", i, d, got[i], exp_seq[i]);
      end
    end
    dsel = 0;
  endtask

  task automatic test_read_miss_hit();
    int lat;
    dsel = 0;
    apply_reset();
    mem_lo = 8'h5A; mem_hi = 8'hA5;
    do_access(0, 17'h01234, 1'b0, 2'b00, 16'h0, 0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL miss_latency got=%0d exp=6", lat); end
    checks++;
    if ({t_hi[1], t_lo[1], t_out[1]} !== {1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL miss_ahi got=%h exp=%h", {t_hi[1], t_lo[1], t_out[1]}, {1'b1, 1'b0, 8'h00});
    end
    checks++;
    if ({t_hi[2], t_lo[2], t_out[2]} !== {1'b1, 1'b1, 8'h24}) begin
      errors++; $display("FAIL miss_amid got=%h exp=%h", {t_hi[2], t_lo[2], t_out[2]}, {1'b1, 1'b1, 8'h24});
    end
    checks++;
    if ({t_hi[3], t_lo[3], t_out[3]} !== {1'b0, 1'b1, 8'h68}) begin
      errors++; $display("FAIL miss_alo got=%h exp=%h", {t_hi[3], t_lo[3], t_out[3]}, {1'b0, 1'b1, 8'h68});
    end
    checks++;
    if ({t_ind[4], t_wr[4], t_out[4], t_ind[5], t_wr[5], t_out[5]} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL miss_data_phases got=%h", {t_ind[4], t_wr[4], t_out[4], t_ind[5], t_wr[5], t_out[5]});
    end
    checks++; if (t_rd !== 16'hA55A) begin errors++; $display("FAIL miss_rdata got=%h exp=a55a", t_rd); end
    mem_lo = 8'h11; mem_hi = 8'h22;
    do_access(0, 17'h01235, 1'b0, 2'b00, 16'h0, 0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL hit_latency got=%0d exp=4", lat); end
    checks++;
    if ({t_hi[1], t_lo[1], t_out[1]} !== {1'b0, 1'b1, 8'h6A}) begin
      errors++; $display("FAIL hit_alo got=%h exp=%h", {t_hi[1], t_lo[1], t_out[1]}, {1'b0, 1'b1, 8'h6A});
    end
    checks++; if (t_rd !== 16'h2211) begin errors++; $display("FAIL hit_rdata got=%h exp=2211", t_rd); end
    checks++; if (o_rd0 !== 16'h2211) begin errors++; $display("FAIL rdata_hold got=%h exp=2211", o_rd0); end
  endtask

  task automatic test_cache_disabled();
    int lat;
    dsel = 1;
    mem_lo = 8'h33; mem_hi = 8'h44;
    do_access(0, 17'h01234, 1'b0, 2'b00, 16'h0, 0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL nocache_first_latency got=%0d exp=6", lat); end
    do_access(0, 17'h01235, 1'b0, 2'b00, 16'h0, 0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL nocache_second_latency got=%0d exp=6", lat); end
    checks++;
    if ({t_hi[1], t_out[1], t_out[3]} !== {1'b1, 8'h00, 8'h6A}) begin
      errors++; $display("FAIL nocache_phases got=%h exp=%h", {t_hi[1], t_out[1], t_out[3]}, {1'b1, 8'h00, 8'h6A});
    end
    checks++; if (t_rd !== 16'h4433) begin errors++; $display("FAIL nocache_rdata got=%h exp=4433", t_rd); end
    dsel = 0;
  endtask

  task automatic test_write_byte();
    int lat;
    int bad;
    dsel = 0;
    // byte address 0x1_0000 is word address 0x0_8000
    do_access(1, 17'h08000, 1'b1, 2'b10, 16'hBEEF, 0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL wr_latency got=%0d exp=5", lat); end
    checks++;
    if ({t_hi[1], t_out[1]} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL wr_ahi got=%h exp=%h", {t_hi[1], t_out[1]}, {1'b1, 8'h01});
    end
    checks++;
    if ({t_wr[4], t_ind[4], t_out[4], t_hi[4], t_lo[4]} !== {1'b1, 1'b1, 8'hBE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL wr_d1 got=%h exp=%h", {t_wr[4], t_ind[4], t_out[4], t_hi[4], t_lo[4]}, {1'b1, 1'b1, 8'hBE, 1'b0, 1'b0});
    end
    bad = 0;
    for (int k = 1; k < 16; k++) if (t_wr[k] && !t_ind[k]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL wr_byte0_touched got=%0d exp=0", bad); end
    checks++; if (o_rd1 !== 16'h0) begin errors++; $display("FAIL wr_rdata1 got=%h exp=0", o_rd1); end
    do_access(1, 17'h08001, 1'b1, 2'b10, 16'h1234, 0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL hit_wr_latency got=%0d exp=3", lat); end
    checks++;
    if ({t_out[1], t_lo[1], t_wr[2], t_ind[2], t_out[2]} !== {8'h02, 1'b1, 1'b1, 1'b1, 8'h12}) begin
      errors++; $display("FAIL hit_wr_phases got=%h exp=%h", {t_out[1], t_lo[1], t_wr[2], t_ind[2], t_out[2]}, {8'h02, 1'b1, 1'b1, 1'b1, 8'h12});
    end
  endtask

  task automatic test_inval();
    int lat;
    dsel = 0;
    inval = 1'b1;
    @(posedge clk); #1 inval = 1'b0;
    do_access(0, 17'h08002, 1'b0, 2'b00, 16'h0, 0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL inval_latency got=%0d exp=6", lat); end
    checks++;
    if ({t_hi[1], t_lo[1], t_hi[2], t_lo[2]} !== 4'b1011) begin
      errors++; $display("FAIL inval_phases got=%b exp=1011", {t_hi[1], t_lo[1], t_hi[2], t_lo[2]});
    end
    // inval coinciding with ALO completion must leave the cache invalid
    do_access(0, 17'h08003, 1'b0, 2'b00, 16'h0, 1, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL inval_alo_hit_latency got=%0d exp=4", lat); end
    do_access(0, 17'h08004, 1'b0, 2'b00, 16'h0, 0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL inval_alo_wins got=%0d exp=6", lat); end
  endtask

  task automatic test_wmask_zero();
    int lat;
    int wr_cycles;
    dsel = 0;
    do_access(0, 17'h08005, 1'b1, 2'b00, 16'hFFFF, 0, lat);
    wr_cycles = 0;
    for (int k = 1; k < 16; k++) if (t_wr[k]) wr_cycles++;
    checks++; if (lat !== 2) begin errors++; $display("FAIL wmask0_latency got=%0d exp=2", lat); end
    checks++; if (wr_cycles !== 0) begin errors++; $display("FAIL wmask0_writes got=%0d exp=0", wr_cycles); end
    checks++;
    if ({t_lo[1], t_out[1]} !== {1'b1, 8'h0A}) begin
      errors++; $display("FAIL wmask0_alo got=%h exp=%h", {t_lo[1], t_out[1]}, {1'b1, 8'h0A});
    end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    int acks;
    logic found;
    dsel = 0;
    r0_addr = 17'h08006; r0_we = 1'b1; r0_wmask = 2'b11; r0_wdata = 16'hCAFE; r0_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #1;
      if (o_wr && !o_ind) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_reach_d0 got=%b exp=1", found); end
    reset = 1'b1; r0_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({o_wr, o_hi, o_lo, o_ack0, o_busy} !== 5'b0) begin
      errors++; $display("FAIL rst_abort got=%b exp=00000", {o_wr, o_hi, o_lo, o_ack0, o_busy});
    end
    reset = 1'b0;
    acks = 0;
    repeat (3) begin @(posedge clk); #1; if (o_ack0 || o_ack1) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_no_ack got=%0d exp=0", acks); end
    do_access(0, 17'h08006, 1'b0, 2'b00, 16'h0, 0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL rst_full_latch got=%0d exp=6", lat); end
    checks++;
    if ({t_hi[1], t_out[1], t_out[2], t_out[3]} !== {1'b1, 8'h01, 8'h00, 8'h0C}) begin
      errors++; $display("FAIL rst_full_phases got=%h exp=%h", {t_hi[1], t_out[1], t_out[2], t_out[3]}, {1'b1, 8'h01, 8'h00, 8'h0C});
    end
  endtask

  task automatic test_strobe_exclusive();
    checks++;
    if (overlap_cnt !== 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp=0", overlap_cnt); end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; dsel = 0; checks = 0; errors = 0; overlap_cnt = 0;
    r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0; inval = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_wmask = '0; r1_wmask = '0; r0_wdata = '0; r1_wdata = '0;
    mem_lo = 8'h00; mem_hi = 8'h00;
    test_reset();
    test_arbitration(0, 4'b1010);
    test_arbitration(2, 4'b0000);
    test_read_miss_hit();
    test_cache_disabled();
    test_write_byte();
    test_inval();
    test_wmask_zero();
    test_reset_mid_access();
    test_strobe_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
